bit_packer: RTL and testbench
=============================

BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 32; half-width of the packed word; W = 2*DATA_WIDTH (64) is the input and output word width.
REQ-002 Parameter LEN_WIDTH, default 8; width of length fields; SHALL satisfy 2^LEN_WIDTH > W.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream code word valid.
REQ-006 in_ready  output  1  packer accepts the word this cycle.
REQ-007 in_data  input  W  merged code bits, MSB-aligned; bits below in_len ignored.
REQ-008 in_len  input  LEN_WIDTH  valid bit count of in_data, 0..W.
REQ-009 in_last  input  1  final code of stream; triggers flush.
REQ-010 out_valid  output  1  out_data holds a word.
REQ-011 out_ready  input  1  downstream accepts the word.
REQ-012 out_data  output  W  packed bits, MSB-first, zero-padded below out_len.
REQ-013 out_len  output  LEN_WIDTH  valid bits in out_data (W except on the final word).
REQ-014 out_last  output  1  marks the final word of a stream.

Function
REQ-015 Accumulator acc: 2*W bits, MSB-aligned; fill counter 0..2*W-1; FSM states RUN, FLUSH.
REQ-016 Input handshake: word accepted on a cycle with in_valid && in_ready; output handshake: out_valid && out_ready.
REQ-017 RUN: out_valid = (fill >= W); out_data = acc[2W-1:W]; out_len = W; out_last = 0.
REQ-018 RUN: in_ready = (fill < W) || (out_valid && out_ready); FLUSH: in_ready = 0.
REQ-019 On output handshake, acc shifts left by W, and fill decreases by W, in the same cycle.
REQ-020 On accept, the top in_len bits of in_data are written into acc starting fill bits below the MSB (after any same-cycle shift), and fill increases by in_len.
REQ-021 Simultaneous accept and emit in one cycle SHALL be applied as emit first, then append; no bits are lost or reordered.
REQ-022 in_len > W SHALL be treated as W; in_len = 0 is accepted with no change to acc or fill.
REQ-023 Bits of acc below fill SHALL be held at zero at all times.
REQ-024 Accept with in_last = 1 moves the FSM to FLUSH on the next cycle, after the append.
REQ-025 FLUSH: out_valid = 1; out_len = min(fill, W); out_last = (fill <= W); out_data = acc[2W-1:W].
REQ-026 FLUSH handshake with out_last = 0 behaves as REQ-019; with out_last = 1 it clears acc and fill and returns to RUN.
REQ-027 Flush with fill = 0 SHALL emit one word with out_len = 0, out_data = 0, out_last = 1.
REQ-028 Latency: a word that completes W bits SHALL drive out_valid on the cycle after the accept.
REQ-029 Outputs SHALL hold stable while out_valid && !out_ready.

Reset
REQ-030 reset low SHALL asynchronously force FSM = RUN, acc = 0, fill = 0, out_valid = 0, out_data = 0, out_len = 0, out_last = 0.
REQ-031 Reset asserted mid-stream or mid-flush SHALL discard all buffered bits; after release, no word is emitted until new input arrives.

Configuration
REQ-032 Macro BIT_PACKER_STATS_EN: when defined, the block SHALL add output word_count (32 bits) that counts output handshakes, is cleared by reset and wraps at 2^32-1 to 0.
REQ-033 When BIT_PACKER_STATS_EN is not defined, the word_count port and its counter SHALL be absent, and all other behaviour is identical.

Verification
REQ-034 Two accepts with in_len = 40 and data 0xFFFFFFFFFF000000 each, out_ready = 1 -> one word 0xFFFFFFFFFFFFFFFF with out_len = 64; fill = 16 remains.
REQ-035 Input 0xA000000000000000 with in_len = 4 and in_last = 1, out_ready = 1 -> out_data 0xA000000000000000, out_len = 4, out_last = 1; FSM back in RUN.
REQ-036 Hold out_ready = 0 with fill = 64 and in_valid high -> in_ready = 0, out_data stable; release out_ready -> emit, then accept in the same cycle.
REQ-037 in_last with in_len = 0 on an empty packer -> single word with out_len = 0, out_last = 1.
REQ-038 Assert reset with fill = 100 in FLUSH -> all outputs 0 immediately, and no word after release; with BIT_PACKER_STATS_EN defined, word_count = 0.
REQ-039 Random in_len stream of 0..64 with random backpressure -> the concatenated output bits match a reference bitstream exactly.

Source files
------------

// File: rtl/bit_packer.sv
// bit_packer: packs variable-length MSB-aligned code words into W-bit output words (W = 2*DATA_WIDTH).
// Ports:
//   clk, reset (asynchronous, active-low)
//   in_valid/in_ready/in_data/in_len/in_last : upstream code words, in_len valid bits from the MSB
//   out_valid/out_ready/out_data/out_len/out_last : packed words, MSB-first, zero-padded below out_len
//   word_count : output handshake counter, present only when BIT_PACKER_STATS_EN is defined
module bit_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_data,
  input  logic [LEN_WIDTH-1:0]    in_len,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic [LEN_WIDTH-1:0]    out_len,
  output logic                    out_last
`ifdef BIT_PACKER_STATS_EN
  ,
  output logic [31:0]             word_count
`endif
);
  localparam int W  = 2*DATA_WIDTH;
  localparam int FW = $clog2(2*W);
  localparam logic [FW-1:0]        W_F = FW'(W);
  localparam logic [LEN_WIDTH-1:0] W_L = LEN_WIDTH'(W);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t               state;
  logic [2*W-1:0]       acc, acc_s, acc_n;
  logic [FW-1:0]        fill, fill_s, fill_n;
  logic [LEN_WIDTH-1:0] len_c;
  logic [W-1:0]         data_m;
  logic                 accept, emit, done;
  assign out_valid = (state == FLUSH) || (fill >= W_F);
  assign out_last  = (state == FLUSH) && (fill <= W_F);
  assign out_data  = acc[2*W-1:W];
  // out_len reads zero while idle so the reset state shows all-zero outputs
  assign out_len   = !out_valid ? '0 : (state == RUN || fill >= W_F) ? W_L : LEN_WIDTH'(fill);
  assign in_ready  = (state == RUN) && ((fill < W_F) || (out_valid && out_ready));
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign done      = emit && out_last;
  // Emit (shift out the top word) is applied first, then the new code is appended at the fill point.
  // Masking the code below its length keeps every acc bit under the fill point at zero.
  always_comb begin
    len_c  = (in_len > W_L) ? W_L : in_len;
    data_m = in_data & ~({W{1'b1}} >> len_c);
    acc_s  = done ? '0 : emit ? acc << W : acc;
    fill_s = done ? '0 : emit ? fill - W_F : fill;
    acc_n  = accept ? acc_s | ({data_m, {W{1'b0}}} >> fill_s) : acc_s;
    fill_n = accept ? fill_s + FW'(len_c) : fill_s;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      acc   <= '0;
      fill  <= '0;
    end else begin
      acc   <= acc_n;
      fill  <= fill_n;
      state <= (accept && in_last) ? FLUSH : done ? RUN : state;
    end
  end
`ifdef BIT_PACKER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) word_count <= '0;
    else if (emit) word_count <= word_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_bit_packer.sv
// tb_bit_packer: self-checking bench for bit_packer using directed scenarios and a bit-queue reference model.
module tb_bit_packer;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_len, out_len;
`ifdef BIT_PACKER_STATS_EN
  logic [31:0] word_count;
`endif
  int checks = 0;
  int errors = 0;

  bit_packer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len(out_len), .out_last(out_last)
`ifdef BIT_PACKER_STATS_EN
    , .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; in_valid = 0; in_data = '0; in_len = '0; in_last = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, out_len, out_data} !== 74'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b last=%b len=%0d data=%h exp all zero", out_valid, out_last, out_len, out_data);
    end
    @(negedge clk); reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_two_40bit();
    out_ready = 1;
    @(negedge clk); in_valid = 1; in_data = 64'hFFFFFFFFFF000000; in_len = 40; in_last = 0;
    #1;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL two40_second_accept got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
    end
    @(negedge clk); in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hFFFFFFFFFFFFFFFF || out_len !== 8'd64 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL two40_word got v=%b data=%h len=%0d last=%b exp v=1 data=ffffffffffffffff len=64 last=0", out_valid, out_data, out_len, out_last);
    end
    @(negedge clk); in_valid = 1; in_data = '0; in_len = 0; in_last = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL two40_residue_idle got valid=%b exp 0", out_valid);
    end
    @(negedge clk); in_valid = 0; in_last = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hFFFF000000000000 || out_len !== 8'd16 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL two40_residue got v=%b data=%h len=%0d last=%b exp v=1 data=ffff000000000000 len=16 last=1", out_valid, out_data, out_len, out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL two40_back_to_run got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_short_last();
    out_ready = 1;
    @(negedge clk); in_valid = 1; in_data = 64'hAFFF00000000FFFF; in_len = 4; in_last = 1;
    @(negedge clk); in_valid = 0; in_last = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hA000000000000000 || out_len !== 8'd4 || out_last !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL short_last got v=%b data=%h len=%0d last=%b ready=%b exp v=1 data=a000000000000000 len=4 last=1 ready=0", out_valid, out_data, out_len, out_last, in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL short_last_run got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d1, d2;
    d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    out_ready = 0;
    @(negedge clk); in_valid = 1; in_data = d1; in_len = 64; in_last = 0;
    @(negedge clk); in_data = d2;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== d1) begin
      errors++;
      $display("FAIL stall_start got ready=%b valid=%b data=%h exp ready=0 valid=1 data=%h", in_ready, out_valid, out_data, d1);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== d1 || out_len !== 8'd64) begin
        errors++;
        $display("FAIL stall_hold got ready=%b valid=%b data=%h len=%0d exp ready=0 valid=1 data=%h len=64", in_ready, out_valid, out_data, out_len, d1);
      end
    end
    @(negedge clk); out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready got %b exp 1", in_ready);
    end
    @(negedge clk); in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== d2) begin
      errors++;
      $display("FAIL stall_second_word got valid=%b data=%h exp valid=1 data=%h", out_valid, out_data, d2);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drained got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_empty_flush();
    out_ready = 1;
    @(negedge clk); in_valid = 1; in_data = {$urandom, $urandom}; in_len = 0; in_last = 1;
    @(negedge clk); in_valid = 0; in_last = 0;
    #1;
    checks++;
    if ({out_valid, out_last, out_len, out_data} !== {1'b1, 1'b1, 8'd0, 64'd0}) begin
      errors++;
      $display("FAIL empty_flush got v=%b last=%b len=%0d data=%h exp v=1 last=1 len=0 data=0", out_valid, out_last, out_len, out_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_flush_done got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_flush();
    out_ready = 0;
    @(negedge clk); in_valid = 1; in_data = {$urandom, $urandom}; in_len = 60; in_last = 0;
    @(negedge clk); in_data = {$urandom, $urandom}; in_len = 40; in_last = 1;
    @(negedge clk); in_valid = 0; in_last = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_len !== 8'd64 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush100_state got v=%b len=%0d last=%b ready=%b exp v=1 len=64 last=0 ready=0", out_valid, out_len, out_last, in_ready);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, out_len, out_data} !== 74'd0) begin
      errors++;
      $display("FAIL async_reset got v=%b last=%b len=%0d data=%h exp all zero", out_valid, out_last, out_len, out_data);
    end
`ifdef BIT_PACKER_STATS_EN
    checks++;
    if (word_count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_count got %0d exp 0", word_count);
    end
`endif
    @(negedge clk); reset = 1'b1; out_ready = 1;
    repeat (5) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet got valid=%b exp 0", out_valid);
      end
    end
  endtask

  task automatic test_random();
    bit          q[$];
    bit          flushing, done, ev, er, elast;
    int          sent, cyc, el, l, emits;
    logic [63:0] w;
    emits = 0;
    for (int s = 0; s < 3; s++) begin
      sent = 0; flushing = 0; done = 0; cyc = 0;
      while (!done && cyc < 20000) begin
        @(negedge clk);
        out_ready = ($urandom % 3) != 0;
        if (!flushing) begin
          in_valid = ($urandom % 4) != 0;
          in_data  = {$urandom, $urandom};
          in_len   = ($urandom % 16 == 0) ? 8'($urandom_range(65, 255)) : 8'($urandom_range(0, 64));
          in_last  = (sent == 149);
        end else begin
          in_valid = 0; in_last = 0;
        end
        #1;
        ev = flushing || q.size() >= 64;
        er = !flushing && (q.size() < 64 || (ev && out_ready));
        checks++;
        if (out_valid !== ev || in_ready !== er) begin
          errors++;
          $display("FAIL rand_handshake got valid=%b ready=%b exp valid=%b ready=%b (stream %0d cycle %0d)", out_valid, in_ready, ev, er, s, cyc);
        end
        if (ev && out_ready) begin
          el    = flushing ? ((q.size() < 64) ? q.size() : 64) : 64;
          elast = flushing && q.size() <= 64;
          w = '0;
          for (int i = 0; i < el; i++) w[63-i] = q.pop_front();
          emits++;
          checks++;
          if (out_data !== w || out_len !== 8'(el) || out_last !== elast) begin
            errors++;
            $display("FAIL rand_word got data=%h len=%0d last=%b exp data=%h len=%0d last=%b", out_data, out_len, out_last, w, el, elast);
          end
          if (elast) begin
            flushing = 0; done = 1;
          end
        end
        if (in_valid && er) begin
          l = (in_len > 64) ? 64 : int'(in_len);
          for (int i = 0; i < l; i++) q.push_back(in_data[63-i]);
          sent++;
          if (in_last) flushing = 1;
        end
        cyc++;
      end
      checks++;
      if (!done || q.size() != 0) begin
        errors++;
        $display("FAIL rand_stream_end got done=%b leftover=%0d exp done=1 leftover=0", done, q.size());
        q.delete();
      end
    end
    in_valid = 0; in_last = 0;
`ifdef BIT_PACKER_STATS_EN
    #1;
    checks++;
    if (word_count !== 32'(emits)) begin
      errors++;
      $display("FAIL rand_word_count got %0d exp %0d", word_count, emits);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_two_40bit();
    test_short_last();
    test_back_to_back();
    test_empty_flush();
    test_reset_mid_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
